// File: rtl/ps2_ctrl_pkg.sv
// rtl/ps2_ctrl_pkg.sv - shared encodings for the PS/2 command sequencer
package ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_TX_FAIL = 2'd1,
    STATUS_TIMEOUT = 2'd2,
    STATUS_BAD_ACK = 2'd3
  } status_e;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

endpackage

// File: rtl/ps2_timeout_counter.sv
// rtl/ps2_timeout_counter.sv - per-phase watchdog, expires on the LIMIT-th enabled cycle
module ps2_timeout_counter #(
  parameter logic [23:0] LIMIT = 24'd2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [23:0] cnt_q, cnt_d;

  // The count holds the number of enabled cycles already spent, so the
  // LIMIT-th cycle is the one that sees LIMIT-1.
  assign expired = enable && (cnt_q == (LIMIT - 24'd1));

  // Next count: clear dominates, saturate once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_command_sequencer.sv
// rtl/ps2_command_sequencer.sv - host command / ACK / response sequencer; PS2_CMD_RETRY_EN enables resend retries
module ps2_command_sequencer
  import ps2_ctrl_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000,
  parameter int          MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic [1:0] cmd_resp_len,
  output logic       cmd_ready,
  output logic [7:0] tx_command,
  output logic       tx_send_command,
  input  logic       tx_command_sent,
  input  logic       tx_error,
  output logic       rx_wait_for_incoming_data,
  input  logic [7:0] rx_received_data,
  input  logic       rx_received_data_en,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic [7:0] scan_data,
  output logic       scan_valid,
  output logic       done,
  output logic [1:0] status
);

  state_e     state_q, state_d;
  status_e    status_q, status_d;
  logic [7:0] cmd_q, cmd_d;
  logic [1:0] len_q, len_d;       // response bytes still expected
  logic       alive_q;            // low until the first edge after reset release
  logic       resp_valid_q, scan_valid_q;
  logic [7:0] resp_data_q, scan_data_q;
  logic       to_clear, to_enable, to_expired;

`ifdef PS2_CMD_RETRY_EN
  logic [3:0] retry_q, retry_d;
`else
  logic       unused_max_retries;
  assign unused_max_retries = ^MAX_RETRIES;
`endif

  // Counter restarts whenever a phase begins or any byte shows up.
  assign to_enable = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RESP);
  assign to_clear  = (state_d != state_q) || rx_received_data_en;

  ps2_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  assign cmd_ready                 = alive_q && (state_q == ST_IDLE);
  assign tx_command                = cmd_q;
  assign tx_send_command           = (state_q == ST_SEND);
  assign rx_wait_for_incoming_data = alive_q && ((state_q == ST_IDLE) ||
                                                 (state_q == ST_WAIT_ACK) ||
                                                 (state_q == ST_WAIT_RESP));
  assign done                      = (state_q == ST_FINISH);
  assign status                    = status_q;
  assign resp_valid                = resp_valid_q;
  assign resp_data                 = resp_data_q;
  assign scan_valid                = scan_valid_q;
  assign scan_data                 = scan_data_q;

  // Sequencer next-state; status only changes on the way into FINISH.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
`ifdef PS2_CMD_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d   = cmd_byte;
          len_d   = cmd_resp_len;
`ifdef PS2_CMD_RETRY_EN
          retry_d = '0;
`endif
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_error) begin
          status_d = STATUS_TX_FAIL;
          state_d  = ST_FINISH;
        end else if (tx_command_sent) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_received_data_en) begin
          if (rx_received_data == PS2_ACK) begin
            if (len_q != 2'd0) begin
              state_d = ST_WAIT_RESP;
            end else begin
              status_d = STATUS_OK;
              state_d  = ST_FINISH;
            end
          end else if (rx_received_data == PS2_RESEND) begin
`ifdef PS2_CMD_RETRY_EN
            if (int'(retry_q) < MAX_RETRIES) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_SEND;
            end else begin
              status_d = STATUS_BAD_ACK;
              state_d  = ST_FINISH;
            end
`else
            status_d = STATUS_BAD_ACK;
            state_d  = ST_FINISH;
`endif
          end else begin
            status_d = STATUS_BAD_ACK;
            state_d  = ST_FINISH;
          end
        end else if (to_expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_FINISH;
        end
      end
      ST_WAIT_RESP: begin
        if (rx_received_data_en) begin
          len_d = len_q - 2'd1;
          if (len_q == 2'd1) begin
            status_d = STATUS_OK;
            state_d  = ST_FINISH;
          end
        end else if (to_expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and latched command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      status_q <= STATUS_OK;
      cmd_q    <= 8'h00;
      len_q    <= 2'd0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      alive_q  <= 1'b1;
    end
  end

`ifdef PS2_CMD_RETRY_EN
  // Resend attempts used by the current command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Route received bytes: responses while waiting for them, scan codes while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      scan_data_q  <= 8'h00;
    end else begin
      resp_valid_q <= rx_received_data_en && (state_q == ST_WAIT_RESP);
      scan_valid_q <= rx_received_data_en && (state_q == ST_IDLE);
      if (rx_received_data_en && (state_q == ST_WAIT_RESP)) begin
        resp_data_q <= rx_received_data;
      end
      if (rx_received_data_en && (state_q == ST_IDLE)) begin
        scan_data_q <= rx_received_data;
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// tb/tb_ps2_command_sequencer.sv - randomized self-checking bench for ps2_command_sequencer
module tb_ps2_command_sequencer;

  localparam int TO   = 100;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic [1:0] cmd_resp_len = 2'd0;
  logic       cmd_ready;
  logic [7:0] tx_command;
  logic       tx_send_command;
  logic       tx_command_sent = 1'b0;
  logic       tx_error = 1'b0;
  logic       rx_wait_for_incoming_data;
  logic [7:0] rx_received_data = 8'h00;
  logic       rx_received_data_en = 1'b0;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       done;
  logic [1:0] status;

  ps2_command_sequencer #(
    .TIMEOUT_CYCLES (24'd100),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .cmd_valid                 (cmd_valid),
    .cmd_byte                  (cmd_byte),
    .cmd_resp_len              (cmd_resp_len),
    .cmd_ready                 (cmd_ready),
    .tx_command                (tx_command),
    .tx_send_command           (tx_send_command),
    .tx_command_sent           (tx_command_sent),
    .tx_error                  (tx_error),
    .rx_wait_for_incoming_data (rx_wait_for_incoming_data),
    .rx_received_data          (rx_received_data),
    .rx_received_data_en       (rx_received_data_en),
    .resp_data                 (resp_data),
    .resp_valid                (resp_valid),
    .scan_data                 (scan_data),
    .scan_valid                (scan_valid),
    .done                      (done),
    .status                    (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // expected outputs for the current cycle, set by the stimulus script
  bit         chk_en = 1'b0;
  logic       e_ready = 1'b0, e_send = 1'b0, e_wait = 1'b0, e_done = 1'b0;
  logic       e_resp_v = 1'b0, e_scan_v = 1'b0;
  logic [7:0] e_txcmd = 8'h00, e_resp_d = 8'h00, e_scan_d = 8'h00;
  logic [1:0] e_status = 2'd0;

  // observed history for literal checks
  int         n_done = 0, n_resp = 0, n_send = 0, n_scan = 0;
  int         last_done_cyc = 0, sent_cyc = 0;
  logic [1:0] last_st = 2'd0;
  logic [7:0] last_resp = 8'h00, last_scan = 8'h00;
  bit         prev_send = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, e_ready);
      chk("tx_send_command", tx_send_command, e_send);
      chk("rx_wait", rx_wait_for_incoming_data, e_wait);
      chk("done", done, e_done);
      chk("status", status, e_status);
      chk("resp_valid", resp_valid, e_resp_v);
      chk("scan_valid", scan_valid, e_scan_v);
      if (e_send)   chk("tx_command", tx_command, e_txcmd);
      if (e_resp_v) chk("resp_data", resp_data, e_resp_d);
      if (e_scan_v) chk("scan_data", scan_data, e_scan_d);
    end
    if (!reset) begin
      prev_send = 1'b0;
    end else begin
      if (done) begin n_done++; last_st = status; last_done_cyc = cyc; end
      if (resp_valid) begin n_resp++; last_resp = resp_data; end
      if (scan_valid) begin n_scan++; last_scan = scan_data; end
      if (tx_send_command && !prev_send) n_send++;
      prev_send = tx_send_command;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    cmd_valid           = 1'b0;
    tx_command_sent     = 1'b0;
    tx_error            = 1'b0;
    rx_received_data_en = 1'b0;
    e_done   = 1'b0;
    e_resp_v = 1'b0;
    e_scan_v = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic rx_set(input logic [7:0] d);
    rx_received_data    = d;
    rx_received_data_en = 1'b1;
  endtask

  // Called in the cycle whose edge completed the command.
  task automatic finish_cmd(input logic [1:0] s);
    e_done = 1'b1; e_status = s; e_send = 1'b0; e_wait = 1'b0; e_ready = 1'b0;
    tick();
    e_ready = 1'b1; e_wait = 1'b1;
  endtask

  task automatic do_reset();
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_tx_send", tx_send_command, 1'b0);
    chk("rst_tx_command", tx_command, 8'h00);
    chk("rst_rx_wait", rx_wait_for_incoming_data, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_scan_valid", scan_valid, 1'b0);
    chk("rst_scan_data", scan_data, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'd0);
    e_ready = 1'b0; e_send = 1'b0; e_wait = 1'b0; e_status = 2'd0; e_txcmd = 8'h00;
    tick();
    tick();
    reset  = 1'b1;
    chk_en = 1'b1;
    tick();
    e_ready = 1'b1; e_wait = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    logic [7:0] d;
    bit         sc;
    for (int i = 0; i < n; i++) begin
      d  = 8'($urandom);
      sc = ($urandom_range(0, 2) == 0);
      if (sc) rx_set(d);
      tick();
      if (sc) begin e_scan_v = 1'b1; e_scan_d = d; end
    end
  endtask

  // ack_kind: 0 ACK, 1 RESEND, 2 other byte, 3 silence, 4 random per attempt
  // ack_gap: cycle of the ACK phase carrying the reply, <=0 picks at random
  task automatic do_cmd(input logic [7:0] b, input logic [1:0] len, input bit fail,
                        input int ack_kind, input int ack_gap, input logic [7:0] rb,
                        input bit resp_to, input bit abort);
    int         retries;
    int         kind;
    int         gap;
    int         r;
    bit         sc;
    logic [7:0] d;
    retries = 0;
    sc = ($urandom_range(0, 3) == 0);
    d  = 8'($urandom);
    cmd_valid = 1'b1; cmd_byte = b; cmd_resp_len = len;
    if (sc) rx_set(d);
    tick();
    if (sc) begin e_scan_v = 1'b1; e_scan_d = d; end
    forever begin
      e_ready = 1'b0; e_send = 1'b1; e_wait = 1'b0; e_txcmd = b;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        if ($urandom_range(0, 2) == 0) rx_set(8'($urandom));
        tick();
      end
      if (fail) begin
        tx_error = 1'b1;
        tx_command_sent = 1'($urandom_range(0, 1));
        tick();
        finish_cmd(2'd1);
        return;
      end
      tx_command_sent = 1'b1;
      if ($urandom_range(0, 3) == 0) rx_set(8'($urandom));
      tick();
      sent_cyc = cyc;
      e_send = 1'b0; e_wait = 1'b1;
      kind = ack_kind;
      if (kind == 4) begin
        r = $urandom_range(0, 9);
        kind = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      end
      if (kind == 3) begin
        repeat (TO) tick();
        finish_cmd(2'd2);
        return;
      end
      gap = ack_gap;
      if (gap <= 0) gap = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(1, 5);
      repeat (gap - 1) tick();
      if (kind == 0) d = 8'hFA;
      else if (kind == 1) d = 8'hFE;
      else begin
        d = 8'($urandom);
        while (d == 8'hFA || d == 8'hFE) d = 8'($urandom);
      end
      rx_set(d);
      tick();
      if (kind == 1) begin
`ifdef PS2_CMD_RETRY_EN
        if (retries < MAXR) begin
          retries++;
          continue;
        end
`endif
        finish_cmd(2'd3);
        return;
      end
      if (kind == 2) begin
        finish_cmd(2'd3);
        return;
      end
      break;
    end
    if (len == 2'd0) begin
      finish_cmd(2'd0);
      return;
    end
    for (int k = 0; k < int'(len); k++) begin
      if (resp_to && k == int'(len) - 1) begin
        repeat (TO) tick();
        finish_cmd(2'd2);
        return;
      end
      gap = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(1, 4);
      repeat (gap - 1) tick();
      d = rb + 8'(k);
      rx_set(d);
      tick();
      e_resp_v = 1'b1; e_resp_d = d;
      if (abort) begin
        do_reset();
        return;
      end
      if (k == int'(len) - 1) finish_cmd(2'd0);
    end
  endtask

  initial begin
    int n0, r0, s0;
    do_reset();

    // idle scan code
    n0 = n_scan;
    rx_set(8'h1C);
    tick();
    e_scan_v = 1'b1; e_scan_d = 8'h1C;
    settle();
    chk("lit_scan_count", n_scan - n0, 1);
    chk("lit_scan_data", last_scan, 8'h1C);

    // F4, no response
    n0 = n_done; r0 = n_resp;
    do_cmd(8'hF4, 2'd0, 1'b0, 0, 3, 8'h00, 1'b0, 1'b0);
    settle();
    chk("lit_f4_done", n_done - n0, 1);
    chk("lit_f4_status", last_st, 2'd0);
    chk("lit_f4_resp", n_resp - r0, 0);

    // FF with one response byte
    r0 = n_resp;
    do_cmd(8'hFF, 2'd1, 1'b0, 0, 2, 8'hAA, 1'b0, 1'b0);
    settle();
    chk("lit_ff_resp_count", n_resp - r0, 1);
    chk("lit_ff_resp_data", last_resp, 8'hAA);
    chk("lit_ff_status", last_st, 2'd0);

    // resend on every attempt
    s0 = n_send;
    do_cmd(8'hED, 2'd0, 1'b0, 1, 2, 8'h00, 1'b0, 1'b0);
    settle();
`ifdef PS2_CMD_RETRY_EN
    chk("lit_resend_sends", n_send - s0, 3);
`else
    chk("lit_resend_sends", n_send - s0, 1);
`endif
    chk("lit_resend_status", last_st, 2'd3);

    // silence until timeout
    do_cmd(8'hF2, 2'd0, 1'b0, 3, 0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("lit_to_status", last_st, 2'd2);
    chk("lit_to_cycle", last_done_cyc - sent_cyc, TO);

    // ACK on the timeout cycle wins
    do_cmd(8'hF2, 2'd0, 1'b0, 0, TO, 8'h00, 1'b0, 1'b0);
    settle();
    chk("lit_late_ack_status", last_st, 2'd0);
    chk("lit_late_ack_cycle", last_done_cyc - sent_cyc, TO);

    // transmitter failure
    do_cmd(8'hF3, 2'd0, 1'b1, 0, 1, 8'h00, 1'b0, 1'b0);
    settle();
    chk("lit_txfail_status", last_st, 2'd1);

    // reset in the middle of the response phase
    n0 = n_done;
    do_cmd(8'hF2, 2'd3, 1'b0, 0, 2, 8'h10, 1'b0, 1'b1);
    settle();
    chk("lit_abort_no_done", n_done - n0, 0);
    chk("lit_abort_ready", cmd_ready, 1'b1);
    chk("lit_abort_status", status, 2'd0);

    for (int i = 0; i < 120; i++) begin
      idle_gap($urandom_range(0, 3));
      do_cmd(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
             4, 0, 8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    idle_gap(3);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ps2_command_sequencer.md
PS2_COMMAND_SEQUENCER -- requirements
Module: ps2_command_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd2000000, meaning clk cycles allowed per wait phase before timeout.
REQ-002 SHALL have parameter MAX_RETRIES, default 2, meaning resend attempts allowed after a 0xFE reply.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  host requests a command.
REQ-006 SHALL have port cmd_byte  input  8  command byte to send.
REQ-007 SHALL have port cmd_resp_len  input  2  response bytes expected after ACK (0-3).
REQ-008 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-009 SHALL have port tx_command  output  8  byte to the PS/2 transmitter.
REQ-010 SHALL have port tx_send_command  output  1  transmitter start request.
REQ-011 SHALL have ports tx_command_sent and tx_error  input  1 each  transmitter completion and failure strobes.
REQ-012 SHALL have port rx_wait_for_incoming_data  output  1  drives the receiver's wait_for_incoming_data.
REQ-013 SHALL have ports rx_received_data (input 8) and rx_received_data_en (input 1)  receiver byte and one-cycle strobe.
REQ-014 SHALL have ports resp_data (output 8) and resp_valid (output 1)  response byte and one-cycle strobe.
REQ-015 SHALL have ports scan_data (output 8) and scan_valid (output 1)  unsolicited bytes received while idle.
REQ-016 SHALL have ports done (output 1 strobe) and status (output 2)  command completion and result: 0 OK, 1 TX_FAIL, 2 TIMEOUT, 3 BAD_ACK.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT_ACK, WAIT_RESP, FINISH.
REQ-018 SHALL assert cmd_ready only in IDLE; handshake cmd_valid&&cmd_ready latches cmd_byte/cmd_resp_len, clears retry count, enters SEND next cycle.
REQ-019 SHALL hold tx_send_command=1 and tx_command=latched byte throughout SEND; tx_command_sent -> WAIT_ACK; tx_error -> FINISH with status 1; tx_error wins if both are asserted.
REQ-020 SHALL hold rx_wait_for_incoming_data=1 in IDLE, WAIT_ACK and WAIT_RESP, and 0 in SEND and FINISH.
REQ-021 In WAIT_ACK, byte 0xFA SHALL go to WAIT_RESP if resp_len>0, else FINISH with status 0.
REQ-022 In WAIT_ACK, any byte other than 0xFA/0xFE SHALL go to FINISH with status 3.
REQ-023 In WAIT_RESP, each byte SHALL pulse resp_valid with resp_data one cycle after rx_received_data_en; after the last byte, FINISH with status 0.
REQ-024 Timeout counter SHALL clear on every state entry and every received byte; reaching TIMEOUT_CYCLES in WAIT_ACK/WAIT_RESP SHALL go to FINISH with status 2; a byte arriving on the timeout cycle SHALL win.
REQ-025 FINISH SHALL last exactly one cycle with done=1 and status valid, then return to IDLE; status SHALL hold until the next done.
REQ-026 In IDLE, each received byte SHALL pulse scan_valid/scan_data one cycle later; a simultaneous command accept SHALL not suppress it.
REQ-027 Bytes arriving in SEND SHALL be discarded.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, counters 0, and outputs tx_command=0x00, tx_send_command=0, cmd_ready=0 while reset is asserted (1 from the first cycle after release), rx_wait_for_incoming_data=0 while reset is asserted, resp/scan data 0x00, all strobes 0, status 0.
REQ-029 A reset mid-command SHALL abandon it without a done pulse.

Configuration
REQ-030 With PS2_CMD_RETRY_EN defined, 0xFE in WAIT_ACK SHALL re-enter SEND if retries<MAX_RETRIES, incrementing the retry count, and otherwise go to FINISH with status 3.
REQ-031 Without PS2_CMD_RETRY_EN, 0xFE SHALL go directly to FINISH with status 3, and no retry counter SHALL exist.

Structure
REQ-032 Package ps2_ctrl_pkg SHALL hold state encodings, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, and the status codes.
REQ-033 Sub-module ps2_timeout_counter (clear, enable, expired) SHALL implement the timeout.

Verification
REQ-034 Send 0xF4, resp_len 0, tx_command_sent, rx 0xFA -> done with status 0, no resp_valid.
REQ-035 Send 0xFF, resp_len 1, rx 0xFA then 0xAA -> resp_valid once with 0xAA, then done with status 0.
REQ-036 With RETRY_EN and MAX_RETRIES=2, rx 0xFE three times -> three SEND phases, then done with status 3.
REQ-037 TIMEOUT_CYCLES=100, no reply -> done with status 2 at cycle 100 of WAIT_ACK; rx byte on that cycle -> no timeout.
REQ-038 Idle rx 0x1C -> scan_valid with 0x1C; tx_error in SEND -> done with status 1.
REQ-039 Reset asserted in WAIT_RESP -> outputs take reset values, no done, cmd_ready=1 after release.
